// File: rtl/shifter_pkg.sv
// Shared types and constants for the nibble deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shifter_pkg;

  // Default output word width.
  localparam int DEF_W = 4;

  // Deserializer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_deser_shift_step.sv
// One-bit insert into a W-bit word, toward the MSB or the LSB end.
// Latency: combinational.
// Backpressure: none.
module shift_step
  import shifter_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] word_in,
  input  logic         bit_in,
  input  logic         dir_in,
  output logic [W-1:0] word_out
);

  // dir_in=0 shifts left (new bit enters at bit 0), dir_in=1 shifts right
  // (new bit enters at bit W-1).
  always_comb begin
    word_out = word_in;
    if (dir_in) begin
      word_out = {bit_in, word_in[W-1:1]};
    end else begin
      word_out = {word_in[W-2:0], bit_in};
    end
  end

endmodule

// File: rtl/nibble_deser.sv
// Serial-to-parallel deserializer: W data bits (plus optional even-parity bit
// when NIBBLE_DESER_PARITY_EN is defined) assembled into o.
// Latency: o_valid rises 1 cycle after the frame's last bit is sampled.
// Backpressure: word held until o_ready; bits arriving while held are dropped
// and flagged on ovr.
module nibble_deser
  import shifter_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         dir,
  output logic [W-1:0] o,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         busy,
  output logic         ovr,
  output logic         perr
);

`ifdef NIBBLE_DESER_PARITY_EN
  localparam int FLEN   = W + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FLEN   = W;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int            CW   = $clog2(W + 2);
  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          dir_l;
  logic          step_dir;
  logic [W-1:0]  shifted;
  logic          start;
  logic          advance;
  logic          last_bit;

  // The first bit of a frame uses the live dir; later bits use the latched one.
  assign step_dir = (state == SHIFT) ? dir_l : dir;

  // A frame starts from IDLE, or from HOLD when the held word is accepted in
  // the same cycle as the next bit arrives.
  assign start    = sin_valid && ((state == IDLE) || ((state == HOLD) && o_ready));
  assign advance  = (state == SHIFT) && sin_valid;
  assign last_bit = advance && (cnt == LAST);

  shift_step #(
    .W (W)
  ) u_step (
    .word_in  (o),
    .bit_in   (sin),
    .dir_in   (step_dir),
    .word_out (shifted)
  );

  // Control FSM, bit counter and the assembled word.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      cnt     <= '0;
      o       <= '0;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      ovr     <= 1'b0;
      dir_l   <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (start) begin
        state   <= SHIFT;
        busy    <= 1'b1;
        o_valid <= 1'b0;
        dir_l   <= dir;
        cnt     <= CW'(1);
        o       <= shifted;
      end else begin
        case (state)
          IDLE: begin
            // waiting for the first bit of a frame
          end
          SHIFT: begin
            if (advance) begin
              cnt <= cnt + 1'b1;
              // the trailing parity bit is checked, never stored in o
              if (!(PAR_EN && last_bit)) begin
                o <= shifted;
              end
              if (last_bit) begin
                state   <= HOLD;
                busy    <= 1'b0;
                o_valid <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (o_ready) begin
              state   <= IDLE;
              o_valid <= 1'b0;
              cnt     <= '0;
            end else if (sin_valid) begin
              ovr <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            o_valid <= 1'b0;
            cnt     <= '0;
          end
        endcase
      end
    end
  end

`ifdef NIBBLE_DESER_PARITY_EN
  logic par_acc;

  // Running XOR over the frame; its final value including the parity bit is
  // the error flag, held with the word.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      par_acc <= 1'b0;
      perr    <= 1'b0;
    end else if (start) begin
      par_acc <= sin;
      perr    <= 1'b0;
    end else if (advance) begin
      par_acc <= par_acc ^ sin;
      if (last_bit) begin
        perr <= par_acc ^ sin;
      end
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_deser.sv
// Self-checking bench for nibble_deser: directed frames plus random traffic
// compared every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_nibble_deser;

  localparam int W = 4;
`ifdef NIBBLE_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int FLEN = W + 1;
`else
  localparam bit PAR = 1'b0;
  localparam int FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         dir = 1'b0;
  logic         o_ready = 1'b0;
  logic [W-1:0] o;
  logic         o_valid;
  logic         busy;
  logic         ovr;
  logic         perr;

  int tests = 0;
  int fails = 0;

  nibble_deser #(.W(W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .dir       (dir),
    .o         (o),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .busy      (busy),
    .ovr       (ovr),
    .perr      (perr)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = collecting a frame, 2 = holding a word.
  int           m_st = 0;
  logic         m_dir = 1'b0;
  logic         bits[$];
  logic [W-1:0] m_word = '0;
  logic         m_perr = 1'b0;
  logic         m_ovr = 1'b0;

  // Word from the collected bits: dir=0 puts the first bit at the MSB,
  // dir=1 puts it at the LSB.
  function automatic logic [W-1:0] assemble();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (m_dir) w[i] = bits[i];
      else       w[W-1-i] = bits[i];
    end
    return w;
  endfunction

  function automatic logic frame_xor();
    logic x;
    x = 1'b0;
    foreach (bits[i]) x ^= bits[i];
    return x;
  endfunction

  task automatic begin_frame(input logic s, input logic d);
    m_dir = d;
    bits.delete();
    bits.push_back(s);
    m_st = 1;
  endtask

  task automatic model_step(input logic sv, input logic s, input logic d, input logic r);
    m_ovr = 1'b0;
    case (m_st)
      0: if (sv) begin_frame(s, d);
      1: if (sv) begin
           bits.push_back(s);
           if (bits.size() == FLEN) begin
             m_word = assemble();
             m_perr = PAR ? frame_xor() : 1'b0;
             m_st = 2;
           end
         end
      default: begin
        if (r && sv) begin_frame(s, d);
        else if (r) m_st = 0;
        else if (sv) m_ovr = 1'b1;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("o_valid", o_valid, m_st == 2);
    chk("busy", busy, m_st == 1);
    chk("ovr", ovr, m_ovr);
    if (m_st != 1) chk("o", o, m_word);
    if (m_st == 2) chk("perr", perr, m_perr);
  endtask

  // One clock: inputs set at the falling edge, outputs checked at the next one.
  task automatic cyc(input logic sv, input logic s, input logic d, input logic r);
    sin_valid = sv; sin = s; dir = d; o_ready = r;
    @(posedge clk);
    model_step(sv, s, d, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    sin_valid = 1'b0; o_ready = 1'b0;
    #2 nrst = 1'b0;
    #1;
    m_st = 0; m_word = '0; m_perr = 1'b0; m_ovr = 1'b0;
    chk("rst_o", o, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_perr", perr, 0);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // Send W data bits, data[W-1] first; dir is only meaningful on the first
  // bit and is randomised afterwards. A parity bit follows when enabled,
  // inverted when flip=1.
  task automatic frame(input logic d, input logic [W-1:0] data, input logic flip);
    for (int i = W - 1; i >= 0; i--)
      cyc(1'b1, data[i], (i == W - 1) ? d : 1'($urandom_range(0, 1)), 1'b0);
`ifdef NIBBLE_DESER_PARITY_EN
    cyc(1'b1, (^data) ^ flip, 1'($urandom_range(0, 1)), 1'b0);
`else
    chk("no_parity_flip_used", {31'd0, flip} & 32'd0, 0);
`endif
  endtask

  initial begin
    // Reset state
    #2;
    chk("init_o", o, 0);
    chk("init_o_valid", o_valid, 0);
    chk("init_busy", busy, 0);
    @(negedge clk);
    nrst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Left fill, then held under backpressure with a dropped bit
    frame(1'b0, 4'b1011, 1'b0);
    chk("l_word", o, 4'b1011);
    chk("l_valid", o_valid, 1);
    chk("l_busy", busy, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("ovr_pulse", ovr, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_cleared", ovr, 0);
    chk("held_word", o, 4'b1011);
    chk("held_valid", o_valid, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("release_valid", o_valid, 0);
    chk("release_word", o, 4'b1011);

    // Right fill with dir wandering mid-frame
    frame(1'b1, 4'b1011, 1'b0);
    chk("r_word", o, 4'b1101);

    // Accept and start the next frame in the same cycle
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("b2b_busy", busy, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef NIBBLE_DESER_PARITY_EN
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
`endif
    chk("b2b_word", o, 4'b1110);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a frame, then a fresh frame
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    frame(1'b0, 4'b0110, 1'b0);
    chk("post_rst_word", o, 4'b0110);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef NIBBLE_DESER_PARITY_EN
    // Correct and wrong parity
    frame(1'b0, 4'b1011, 1'b0);
    chk("par_ok_perr", perr, 0);
    chk("par_ok_word", o, 4'b1011);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 4'b1011, 1'b1);
    chk("par_bad_perr", perr, 1);
    chk("par_bad_word", o, 4'b1011);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
